// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared constants and helpers for the UART transmit arbiter.
//   State encoding : StIdle, StSend, StStrobe, StGuard (2-bit legacy constants)
//   ByteW          : serial byte width (8)
//   MaxLanes       : largest supported requester count (8)
//   laneByte()     : extracts byte lane idx from a packed lane vector
package uart_tx_arbiter_pkg;

    localparam int ByteW    = 8;
    localparam int MaxLanes = 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSend   = 2'd1;
    localparam logic [1:0] StStrobe = 2'd2;
    localparam logic [1:0] StGuard  = 2'd3;

    typedef logic [ByteW-1:0] byte_t;

    function automatic byte_t laneByte(input logic [MaxLanes*ByteW-1:0] lanes, input int idx);
        return lanes[idx*ByteW +: ByteW];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req      in  NumReq   request vector
//   ptr      in  IdxW     last-granted index; search starts at ptr+1 mod NumReq
//   winner   out NumReq   one-hot winner, zero when nothing requests
//   anyValid out 1        at least one request present
module rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] winner,
    output logic              anyValid
);

    always_comb begin
        int idx;
        winner   = '0;
        anyValid = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = (int'(ptr) + k) % NumReq;
            if (!anyValid && req[idx]) begin
                winner[idx] = 1'b1;
                anyValid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one 8-bit UART transmitter.
//   clk         in  1         system clock
//   rst_n       in  1         asynchronous active-low reset
//   req_valid   in  NumReq    lane i holds a byte
//   req_data    in  8*NumReq  byte lanes, lane i at [8i+7:8i]
//   req_last    in  NumReq    byte on lane i ends its packet
//   req_ready   out NumReq    combinational accept pulse
//   grant       out NumReq    registered one-hot transmitter owner, zero when idle
//   tx_start    out 1         registered one-cycle start strobe
//   tx_data     out 8         registered byte, held until the next accept
//   tx_busy     in  1         transmitter busy, rises the cycle after tx_start
//   arb_timeout out 1         one-cycle pulse when the watchdog revokes a grant
// Optional feature: define UART_ARB_TIMEOUT_EN to build the stalled-grant watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int TimeoutCycles = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NumReq-1:0]     req_valid,
    input  logic [8*NumReq-1:0]   req_data,
    input  logic [NumReq-1:0]     req_last,
    output logic [NumReq-1:0]     req_ready,
    output logic [NumReq-1:0]     grant,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  arb_timeout
);

    localparam int IdxW = $clog2(NumReq);

    logic [1:0]                  state;
    logic [NumReq-1:0]           grantQ;
    logic [NumReq-1:0]           winner;
    logic                        anyValid;
    logic [IdxW-1:0]             ptr;
    logic [IdxW-1:0]             grantIdx;
    logic [IdxW-1:0]             winIdx;
    logic                        lastQ;
    logic                        txStartQ;
    byte_t                       txDataQ;
    logic                        accept;
    logic                        timeoutQ;
    logic                        stallHit;
    logic [MaxLanes*ByteW-1:0]   lanesExt;

    assign lanesExt = (MaxLanes*ByteW)'(req_data);

    rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) uPick (
        .req     (req_valid),
        .ptr     (ptr),
        .winner  (winner),
        .anyValid(anyValid)
    );

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NumReq; i++)
            if (winner[i]) winIdx = IdxW'(i);
    end

    // Only the granted lane can ever see ready, and only while the transmitter is free.
    assign accept    = (state == StSend) && !tx_busy && req_valid[grantIdx];
    assign req_ready = ((state == StSend) && !tx_busy) ? (grantQ & req_valid) : '0;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] idleCnt;

    // Counts only cycles where the owner has nothing to offer; waiting on tx_busy is not a stall.
    assign stallHit = (state == StSend) && !req_valid[grantIdx] &&
                      (idleCnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idleCnt <= '0;
        else if (state == StIdle || accept)
            idleCnt <= '0;
        else if (state == StSend && !req_valid[grantIdx])
            idleCnt <= idleCnt + 1'b1;
    end
`else
    assign stallHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            grantQ   <= '0;
            ptr      <= IdxW'(NumReq - 1);
            grantIdx <= '0;
            lastQ    <= 1'b0;
            txStartQ <= 1'b0;
            txDataQ  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            txStartQ <= 1'b0;
            timeoutQ <= 1'b0;
            case (state)
                StIdle: begin
                    if (anyValid) begin
                        grantQ   <= winner;
                        grantIdx <= winIdx;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    if (accept) begin
                        txDataQ  <= laneByte(lanesExt, int'(grantIdx));
                        lastQ    <= req_last[grantIdx];
                        txStartQ <= 1'b1;
                        state    <= StStrobe;
                    end else if (stallHit) begin
                        grantQ   <= '0;
                        ptr      <= grantIdx;
                        timeoutQ <= 1'b1;
                        state    <= StIdle;
                    end
                end
                StStrobe: state <= StGuard;
                default: begin
                    // Dead cycle so tx_busy is visible before the next accept decision.
                    if (lastQ) begin
                        grantQ <= '0;
                        ptr    <= grantIdx;
                        state  <= StIdle;
                    end else begin
                        state <= StSend;
                    end
                end
            endcase
        end
    end

    assign grant       = grantQ;
    assign tx_start    = txStartQ;
    assign tx_data     = txDataQ;
    assign arb_timeout = timeoutQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter (4 requesters).
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 100000;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            arb_timeout;

    int checks = 0;
    int errors = 0;

    logic [11:0] expQ[$];
    logic [8:0]  laneMem[N][32];
    int          head[N];
    int          tail[N];
    logic [N-1:0] popPend;
    int          busyCnt;
    bit          forceBusy;
    int          startCount;
    int          acceptCount;
    logic [N-1:0] leakSeen;
    bit          sawTimeout;

    uart_tx_arbiter #(.NumReq(N), .TimeoutCycles(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .arb_timeout(arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 900000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushByte(input int lane, input logic [7:0] d, input bit last, input bit expectIt);
        logic [3:0] oh;
        oh = 4'b0001 << lane;
        laneMem[lane][tail[lane] % 32] = {last, d};
        tail[lane]++;
        if (expectIt) expQ.push_back({oh, d});
    endtask

    task automatic waitIdle(input string tag);
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (expQ.size() == 0) && (grant == '0) && !tx_busy &&
                   (head[0] == tail[0]) && (head[1] == tail[1]) &&
                   (head[2] == tail[2]) && (head[3] == tail[3]);
        end
        chk({"idle_", tag}, 32'(done), 32'd1);
    endtask

    always @(posedge clk) begin
        popPend = req_ready;
        acceptCount += $countones(req_ready);
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n) begin
            leakSeen   |= req_ready & ~grant;
            sawTimeout |= arb_timeout;
            if (tx_start) begin
                startCount++;
                if (expQ.size() == 0) begin
                    chk("unexpected_start", {20'd0, grant, tx_data}, 32'hFFF);
                end else begin
                    e = expQ.pop_front();
                    chk("tx_grant_byte", {20'd0, grant, tx_data}, {20'd0, e});
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (popPend[i]) head[i]++;
            req_valid[i]      = head[i] != tail[i];
            req_data[8*i +: 8] = laneMem[i][head[i] % 32][7:0];
            req_last[i]       = laneMem[i][head[i] % 32][8];
        end
        popPend = '0;
        if (tx_start && rst_n) busyCnt = 20;
        tx_busy = forceBusy || (busyCnt > 0);
        if (busyCnt > 0) busyCnt--;
    end

    initial begin
        bit seen;
        int k;
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        forceBusy = 0; busyCnt = 0; popPend = '0; leakSeen = '0; sawTimeout = 0;
        startCount = 0; acceptCount = 0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_arb_timeout", 32'(arb_timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        pushByte(0, 8'h10, 0, 1); pushByte(0, 8'h11, 1, 1);
        pushByte(2, 8'h20, 0, 1); pushByte(2, 8'h21, 1, 1);
        waitIdle("rr_first");
        pushByte(0, 8'h12, 1, 1); pushByte(2, 8'h22, 1, 1);
        waitIdle("rr_second");

        startCount = 0;
        pushByte(0, 8'h41, 0, 1); pushByte(0, 8'h42, 0, 1); pushByte(0, 8'h43, 1, 1);
        waitIdle("single_pkt");
        chk("single_starts", 32'(startCount), 32'd3);
        chk("single_grant_clear", 32'(grant), 32'd0);

        pushByte(1, 8'h61, 0, 1); pushByte(1, 8'h62, 0, 1);
        pushByte(1, 8'h63, 0, 1); pushByte(1, 8'h64, 1, 1);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = grant == 4'b0010;
        end
        chk("pkt_grant1", 32'(seen), 32'd1);
        pushByte(3, 8'h71, 1, 1);
        waitIdle("no_interleave");

        forceBusy = 1;
        repeat (2) @(negedge clk);
        acceptCount = 0; startCount = 0;
        pushByte(0, 8'h55, 1, 1);
        repeat (500) @(negedge clk);
        chk("busy_accepts", 32'(acceptCount), 32'd0);
        chk("busy_starts", 32'(startCount), 32'd0);
        forceBusy = 0;
        waitIdle("busy_release");
        chk("busy_one_accept", 32'(acceptCount), 32'd1);
        chk("busy_one_start", 32'(startCount), 32'd1);

        pushByte(1, 8'h81, 0, 1); pushByte(1, 8'h82, 1, 0);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = tx_start;
        end
        chk("rst_strobe_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_tx_start", 32'(tx_start), 32'd0);
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_tx_data", 32'(tx_data), 32'd0);
        for (int i = 0; i < N; i++) head[i] = tail[i];
        busyCnt = 0; popPend = '0;
        @(negedge clk);
        rst_n = 1'b1;
        pushByte(0, 8'h90, 1, 1); pushByte(3, 8'h93, 1, 1);
        waitIdle("post_reset_rr");

`ifdef UART_ARB_TIMEOUT_EN
        pushByte(1, 8'hA1, 0, 1);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = tx_start && grant == 4'b0010;
        end
        chk("to_first_byte", 32'(seen), 32'd1);
        pushByte(2, 8'hB2, 1, 1);
        k = 0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            k++;
            seen = arb_timeout;
        end
        chk("to_delay", 32'(k), 32'd18);
        chk("to_grant_clear", 32'(grant), 32'd0);
        @(negedge clk);
        chk("to_pulse_len", 32'(arb_timeout), 32'd0);
        waitIdle("to_next_grant");
`else
        k = 0;
        chk("no_timeout_pulse", 32'(sawTimeout), 32'd0);
`endif
        chk("ready_leak", 32'(leakSeen), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8-bit RS-232 transmitter (start/data/busy handshake) between `NumReq` byte-stream requesters. Requesters are granted in round-robin order. A grant is held for a whole packet, so bytes from different requesters never interleave on the serial line. The block sits between the command/telemetry producers and the transmitter, on the same clock as the receiver and baud tick generators.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `TimeoutCycles`, 100000: idle limit in clocks for a granted requester (used only with the macro).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NumReq  requester i has a byte on its lane.
- `req_data`  in  8*NumReq  byte lanes; lane i is bits [8i+7:8i].
- `req_last`  in  NumReq  the byte on lane i ends its packet.
- `req_ready`  out  NumReq  combinational one-cycle accept pulse to requester i.
- `grant`  out  NumReq  registered one-hot owner of the transmitter; all-zero when idle.
- `tx_start`  out  1  registered one-cycle start strobe to the transmitter.
- `tx_data`  out  8  registered byte to the transmitter; stable from `tx_start` until the next accept.
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_start`.
- `arb_timeout`  out  1  registered one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- Reset values: `grant`=0, `tx_start`=0, `tx_data`=0x00, `arb_timeout`=0, state IDLE, last-granted pointer = NumReq-1, so requester 0 has first priority.
- `req_ready[i]` = (state==SEND) & `grant[i]` & `req_valid[i]` & ~`tx_busy`. It is never asserted for a non-granted lane.
- States:
  - IDLE: if any `req_valid` is high, pick the first valid requester searching from pointer+1 modulo NumReq, register `grant`, go to SEND. If none is valid, stay.
  - SEND: on accept, register `tx_data` = granted lane, latch `req_last`, go to STROBE. Otherwise hold.
  - STROBE: `tx_start`=1 for this cycle only, go to GUARD.
  - GUARD: one dead cycle that covers the transmitter's busy latency. If the latched last is set, clear `grant`, set pointer = granted index, go to IDLE. Otherwise go to SEND.
- Bytes are delivered to the transmitter in acceptance order. Data on non-granted lanes is ignored and left pending.
- Packet integrity:
  - Without the macro, a granted requester that drops `req_valid` mid-packet keeps the grant indefinitely.
  - A single-byte packet (`req_last` on the first byte) releases the grant after one byte.
- `tx_busy` stuck high: the block waits in SEND and never issues `tx_start`.
- Reset mid-packet: outputs return to reset values at once. A byte already started completes on the line on its own.
- When several requesters become valid in the same cycle, round-robin order decides. Fairness guarantee: one packet per requester per round.

## Timing
- Accept (SEND) -> `tx_start` high on the next cycle.
- Minimum spacing between accepts is 3 clocks. In practice spacing is bounded by the serial frame time.
- IDLE with valid request -> `grant` registered 1 cycle later -> earliest accept 1 cycle after that.
- Last byte: `grant` clears on the cycle after GUARD. IDLE may re-grant on the following cycle.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In SEND, a counter increments on each cycle where `req_valid[grant]`==0. It clears on accept and on every entry to SEND from IDLE.
  - Counter reaching TimeoutCycles-1: next cycle `arb_timeout`=1, `grant`=0, pointer = granted index, state IDLE.
  - Cycles spent waiting on `tx_busy` with valid high do not count.
- Not defined: no counter is built, `arb_timeout` is tied 0, and grants are held until `req_last`.

## Structure
- Shared package: state encoding constants (IDLE, SEND, STROBE, GUARD), byte width 8, and the lane-slicing helper.
- One sub-module, `rr_pick`: purely combinational, takes request vector and pointer, returns a one-hot winner and an any-valid flag.

## Test plan
- Single requester, packet 0x41,0x42,0x43 (last on 0x43), tx_busy model 20 cycles per byte:
  - `tx_data` sequence is 0x41, 0x42, 0x43.
  - `tx_start` is seen 3 times.
  - `grant` returns to 0.
- Requesters 0 and 2 valid in the same cycle after reset: 0 is granted first, 2 after 0's last byte. Then re-request both: 2 is not granted twice in a row.
- Requester 1 is sending a 4-byte packet while requester 3 raises valid: no byte from 3 appears until 1's `req_last` is accepted.
- `tx_busy` forced high for 500 cycles with requester 0 valid: no `req_ready` and no `tx_start` until busy drops, then exactly one accept.
- `rst_n` pulsed low during STROBE: `tx_start`, `grant` and `tx_data` go to 0 asynchronously, and arbitration restarts with requester 0 priority.
- With `UART_ARB_TIMEOUT_EN` and TimeoutCycles=16, requester 1 stalls after its first byte:
  - `arb_timeout` pulses 16 cycles after stalling.
  - `grant` clears.
  - Requester 2, if valid, is granted next.
